sd_slv_rsp_seq: RTL

Response sequencer for the SD slave model. It snapshots the decoded command on each `ok` pulse from the command parser and selects the response format (none/R1/R2/R3/R6) from the command index, application-command context and the card state supplied by the card state machine. After the NCR gap it serialises the response onto the CMD line, drives the output enable, and pulses `rsp_end` so the card state machine can drop back to 48-bit framing.

---
 rtl/sd_slv_rsp_seq_if.sv | 35 +++
 rtl/sd_slv_rsp_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sd_slv_rsp_seq_if.sv
// ============================================================================
// Module   : sd_slv_rsp_seq_if
// Brief    : Command-snapshot inputs and CMD-line outputs of the SD response sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sd_slv_rsp_seq_if;
    logic         ok;
    logic [5:0]   ind;
    logic [3:0]   c_state;
    logic [31:0]  status;
    logic [31:0]  ocr;
    logic         pwr_up;
    logic [127:0] cid;
    logic [127:0] csd;
    logic [15:0]  rca;
    logic         cmd_o;
    logic         cmd_oe;
    logic         busy;
    logic         rsp_end;
    logic [2:0]   rsp_type;

    modport master (
        output ok, ind, c_state, status, ocr, pwr_up, cid, csd, rca,
        input  cmd_o, cmd_oe, busy, rsp_end, rsp_type
    );

    modport slave (
        input  ok, ind, c_state, status, ocr, pwr_up, cid, csd, rca,
        output cmd_o, cmd_oe, busy, rsp_end, rsp_type
    );
endinterface

`default_nettype wire

// File: rtl/sd_slv_rsp_seq.sv
// ============================================================================
// Module   : sd_slv_rsp_seq
// Brief    : SD slave response sequencer: selects R1/R2/R3/R6, waits NCR, serialises on CMD.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sd_slv_rsp_seq #(
    parameter int NCR   = 2,
    parameter bit STUFF = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sd_slv_rsp_seq_if.slave   bus
);

    localparam logic [2:0] c_RSP_NONE = 3'd0;
    localparam logic [2:0] c_RSP_R1   = 3'd1;
    localparam logic [2:0] c_RSP_R2   = 3'd2;
    localparam logic [2:0] c_RSP_R3   = 3'd3;
    localparam logic [2:0] c_RSP_R6   = 3'd6;
    localparam logic [7:0] c_LAST_48  = 8'd47;
    localparam logic [7:0] c_LAST_136 = 8'd135;
    localparam logic [7:0] c_CRC_LO   = 8'd40;
    localparam logic [6:0] c_NCR_LOAD = 7'(NCR - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_app;
    logic [2:0]   r_type;
    logic [135:0] r_frame;
    logic [7:0]   r_bit;
    logic [7:0]   r_last;
    logic [6:0]   r_cnt;
    logic [6:0]   r_crc;
    logic         r_use_crc;

    logic [2:0]   w_sel_type;
    logic         w_sel_csd;
    logic [127:0] w_reg;
    logic [135:0] w_frame;
    logic         w_accept;
    logic         w_in_crc;
    logic         w_fb;
    logic [6:0]   w_crc_next;
    logic         w_unused_bits;

    assign w_unused_bits = ^{bus.ocr[31], bus.cid[0], bus.csd[0]};
    assign w_accept      = bus.ok && (r_state == S_IDLE);

    // Selection sees the app flag before this command updates it.
    always_comb begin
        w_sel_type = c_RSP_NONE;
        w_sel_csd  = 1'b0;
        case (bus.ind)
            6'd2:  if (bus.c_state == 4'd1) w_sel_type = c_RSP_R2;
            6'd9:  begin w_sel_type = c_RSP_R2; w_sel_csd = 1'b1; end
            6'd10: w_sel_type = c_RSP_R2;
            6'd3:  if (bus.c_state == 4'd2) w_sel_type = c_RSP_R6;
            6'd41: if (r_app) w_sel_type = c_RSP_R3;
            6'd6:  if (r_app) w_sel_type = c_RSP_R1;
            6'd7, 6'd16, 6'd17, 6'd55: w_sel_type = c_RSP_R1;
            default: w_sel_type = c_RSP_NONE;
        endcase
    end

    assign w_reg = w_sel_csd ? bus.csd : bus.cid;

    // 48-bit frames sit in the top of the shifter; CRC field is preset to ones.
    always_comb begin
        w_frame = '0;
        case (w_sel_type)
            c_RSP_R1: w_frame = {2'b00, bus.ind, bus.status, 7'h7F, 1'b1, 88'd0};
            c_RSP_R6: w_frame = {2'b00, 6'd3, bus.rca, bus.status[23], bus.status[22],
                                 bus.status[19], bus.status[12:0], 7'h7F, 1'b1, 88'd0};
            c_RSP_R3: w_frame = {2'b00, 6'h3F, bus.pwr_up, bus.ocr[30:0], 7'h7F, 1'b1, 88'd0};
            c_RSP_R2: w_frame = {2'b00, 6'h3F, w_reg[127:1], 1'b1};
            default:  w_frame = '0;
        endcase
    end

    assign w_in_crc   = r_use_crc && (r_bit >= c_CRC_LO) && (r_bit < c_LAST_48);
    assign w_fb       = r_frame[135] ^ r_crc[6];
    assign w_crc_next = {r_crc[5:0], 1'b0} ^ {3'b000, w_fb, 2'b00, w_fb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        bus.cmd_o    = STUFF;
        bus.cmd_oe   = 1'b0;
        bus.rsp_end  = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept && (w_sel_type != c_RSP_NONE)) w_next = S_WAIT;
            S_WAIT: if (r_cnt == 7'd0) w_next = S_SEND;
            S_SEND: begin
                bus.cmd_oe = 1'b1;
                bus.cmd_o  = w_in_crc ? r_crc[6] : r_frame[135];
                if (r_bit == r_last) w_next = S_DONE;
            end
            S_DONE: begin
                bus.rsp_end = 1'b1;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_app     <= 1'b0;
            r_type    <= c_RSP_NONE;
            r_frame   <= '0;
            r_bit     <= '0;
            r_last    <= '0;
            r_cnt     <= '0;
            r_crc     <= '0;
            r_use_crc <= 1'b0;
        end else if (w_accept) begin
            r_app     <= (bus.ind == 6'd55);
            r_type    <= w_sel_type;
            r_frame   <= w_frame;
            r_bit     <= '0;
            r_last    <= (w_sel_type == c_RSP_R2) ? c_LAST_136 : c_LAST_48;
            r_cnt     <= c_NCR_LOAD;
            r_crc     <= '0;
            r_use_crc <= (w_sel_type == c_RSP_R1) || (w_sel_type == c_RSP_R6);
        end else begin
            case (r_state)
                S_WAIT: if (r_cnt != 7'd0) r_cnt <= r_cnt - 7'd1;
                S_SEND: begin
                    r_frame <= {r_frame[134:0], 1'b0};
                    if (r_bit != r_last) r_bit <= r_bit + 8'd1;
                    r_crc <= (r_bit < c_CRC_LO) ? w_crc_next : {r_crc[5:0], 1'b0};
                end
                S_DONE: r_type <= c_RSP_NONE;
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.rsp_type = r_type;

endmodule

`default_nettype wire
